// File: rtl/prng_pkg.sv
// Shared constants and FSM encoding for the round-robin PRNG arbiter.
package prng_pkg;
  localparam int WIDTH = 8;
  localparam int SEED  = 251;
  localparam int A     = 233;
  localparam int C     = 197;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP  = 2'd1,
    GRANT = 2'd2
  } fsm_t;
endpackage

// File: rtl/lcg_core.sv
// 8-bit (WIDTH) linear congruential generator: resets to SEED, loads load_val, or steps once.
// Load has priority over step; state updates on the cycle after the request.
module lcg_core
  import prng_pkg::*;
#(
  parameter int WIDTH_P = prng_pkg::WIDTH,
  parameter int SEED_P  = prng_pkg::SEED,
  parameter int A_P     = prng_pkg::A,
  parameter int C_P     = prng_pkg::C
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               step,
  input  logic               load,
  input  logic [WIDTH_P-1:0] load_val,
  output logic [WIDTH_P-1:0] state
);
  localparam logic [WIDTH_P-1:0] A_W    = WIDTH_P'(A_P);
  localparam logic [WIDTH_P-1:0] C_W    = WIDTH_P'(C_P);
  localparam logic [WIDTH_P-1:0] SEED_W = WIDTH_P'(SEED_P);

  logic [WIDTH_P-1:0] state_q, state_d;

  // WIDTH-bit arithmetic context gives the mod 2^WIDTH truncation for free.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = load_val;
    end else if (step) begin
      state_d = state_q * A_W + C_W;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED_W;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;
endmodule

// File: rtl/prng_arbiter.sv
// Round-robin sharing of one LCG among N_REQ requesters; grant 2 cycles after arbitration, one per 3 cycles.
// Reseeds arriving while busy are deferred to the next IDLE. PRNG_ARB_STATS_EN adds a saturating grant_cnt.
module prng_arbiter
  import prng_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = prng_pkg::WIDTH,
  parameter int SEED  = prng_pkg::SEED,
  parameter int A     = prng_pkg::A,
  parameter int C     = prng_pkg::C
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             reseed,
  input  logic [WIDTH-1:0] seed_in,
  output logic [N_REQ-1:0] gnt,
  output logic [WIDTH-1:0] num,
  output logic             busy
`ifdef PRNG_ARB_STATS_EN
  ,
  output logic [15:0]      grant_cnt
`endif
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  fsm_t             state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, win_q, win_d, pick;
  logic             pick_vld;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] pseed_q, pseed_d;
  logic             lcg_step, lcg_load;
  logic [WIDTH-1:0] lcg_val, lcg_state;
  int unsigned      j;

  lcg_core #(
    .WIDTH_P (WIDTH),
    .SEED_P  (SEED),
    .A_P     (A),
    .C_P     (C)
  ) u_lcg (
    .clk      (clk),
    .rst_n    (rst_n),
    .step     (lcg_step),
    .load     (lcg_load),
    .load_val (lcg_val),
    .state    (lcg_state)
  );

  // First asserted request at or after ptr, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    j        = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr_q) + k) % N_REQ;
      if (!pick_vld && req[j]) begin
        pick_vld = 1'b1;
        pick     = IDX_W'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!reseed && !pend_q && pick_vld) state_d = STEP;
      STEP:    state_d = GRANT;
      GRANT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lcg_load = (state_q == IDLE) && (reseed || pend_q);
    lcg_val  = reseed ? seed_in : pseed_q;
    lcg_step = (state_q == STEP);
    busy     = (state_q != IDLE);
    gnt      = '0;
    num      = '0;
    if (state_q == GRANT) begin
      gnt[win_q] = 1'b1;
      num        = lcg_state;
    end
  end

  // A fresh reseed in IDLE supersedes a pending one, so IDLE always empties the pending slot.
  always_comb begin
    ptr_d   = ptr_q;
    win_d   = win_q;
    pend_d  = pend_q;
    pseed_d = pseed_q;
    if (state_q == IDLE) begin
      pend_d = 1'b0;
      if (!reseed && !pend_q && pick_vld) win_d = pick;
    end else if (reseed) begin
      pend_d  = 1'b1;
      pseed_d = seed_in;
    end
    if (state_q == GRANT) begin
      ptr_d = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      win_q   <= '0;
      pend_q  <= 1'b0;
      pseed_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      pend_q  <= pend_d;
      pseed_q <= pseed_d;
    end
  end

`ifdef PRNG_ARB_STATS_EN
  logic [15:0] grant_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_q <= '0;
    end else if (lcg_load) begin
      grant_cnt_q <= '0;
    end else if (state_q == GRANT && grant_cnt_q != 16'hFFFF) begin
      grant_cnt_q <= grant_cnt_q + 16'd1;
    end
  end

  assign grant_cnt = grant_cnt_q;
`endif
endmodule

// File: tb/tb_prng_arbiter.sv
// Directed bench for prng_arbiter with a cycle-level reference model checked every cycle.
module tb_prng_arbiter;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic       reseed = 1'b0;
  logic [7:0] seed_in = '0;
  logic [3:0] gnt;
  logic [7:0] num;
  logic       busy;
`ifdef PRNG_ARB_STATS_EN
  logic [15:0] grant_cnt;
`endif

  prng_arbiter #(.N_REQ(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .reseed  (reseed),
    .seed_in (seed_in),
    .gnt     (gnt),
    .num     (num),
    .busy    (busy)
`ifdef PRNG_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: lcg value, round-robin pointer, deferred reseed, and
  // m_cd = cycles remaining until the arbiter is free (2 = stepping, 1 = granting).
  int m_lcg, m_ptr, m_w, m_cd, m_pseed, m_cnt;
  bit m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lcg = 251; m_ptr = 0; m_w = 0; m_cd = 0; m_pend = 0; m_pseed = 0; m_cnt = 0;
    end else if (m_cd == 0) begin
      if (reseed) begin
        m_lcg = seed_in; m_pend = 0; m_cnt = 0;
      end else if (m_pend) begin
        m_lcg = m_pseed; m_pend = 0; m_cnt = 0;
      end else if (req != 0) begin
        for (int k = N - 1; k >= 0; k--)
          if (req[(m_ptr + k) % N]) m_w = (m_ptr + k) % N;
        m_cd = 2;
      end
    end else begin
      if (reseed) begin
        m_pend = 1; m_pseed = seed_in;
      end
      if (m_cd == 2) m_lcg = (233 * m_lcg + 197) % 256;
      if (m_cd == 1) begin
        m_ptr = (m_w + 1) % N;
        if (m_cnt < 65535) m_cnt++;
      end
      m_cd--;
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("gnt", int'(gnt), (m_cd == 1) ? (1 << m_w) : 0);
      check("num", int'(num), (m_cd == 1) ? m_lcg : 0);
      check("busy", int'(busy), (m_cd != 0) ? 1 : 0);
`ifdef PRNG_ARB_STATS_EN
      check("grant_cnt", int'(grant_cnt), m_cnt);
`endif
    end
  end

  task automatic wait_gnt(input int budget, output int idx, output int val, output int at);
    bit found;
    found = 0; idx = -1; val = -1; at = -1;
    for (int i = 0; i < budget && !found; i++) begin
      @(posedge clk); #1;
      if (gnt != 0) begin
        found = 1;
        val = num;
        at = cyc;
        for (int b = 0; b < N; b++) if (gnt[b]) idx = b;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL gnt_timeout: got no grant expected one within %0d cycles", budget);
    end
  endtask

  // Leaves the bench at a negedge with rst_n just released and req = r.
  task automatic do_reset(input logic [3:0] r);
    @(negedge clk);
    rst_n = 1'b0; req = '0; reseed = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; req = r;
  endtask

  int idx, val, at, t0, prev;
  int exp_num5[5] = '{56, 189, 202, 159, 124};
  int exp_idx5[5] = '{0, 1, 2, 3, 0};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_gnt", int'(gnt), 0);
    check("reset_num", int'(num), 0);
    check("reset_busy", int'(busy), 0);
    chk_en = 1'b1;

    // Single persistent requester
    do_reset(4'b0001);
    t0 = cyc;
    wait_gnt(10, idx, val, at);
    check("single_idx0", idx, 0); check("single_num0", val, 56); check("single_lat", at - t0, 2);
    prev = at;
    wait_gnt(10, idx, val, at);
    check("single_num1", val, 189); check("single_gap1", at - prev, 3);
    prev = at;
    wait_gnt(10, idx, val, at);
    check("single_num2", val, 202); check("single_gap2", at - prev, 3);

    // All requesters: round-robin order with wrap
    do_reset(4'b1111);
    for (int g = 0; g < 5; g++) begin
      wait_gnt(10, idx, val, at);
      check($sformatf("rr_idx%0d", g), idx, exp_idx5[g]);
      check($sformatf("rr_num%0d", g), val, exp_num5[g]);
    end

    // Reseed and request together in IDLE: reseed wins
    do_reset(4'b0000);
    @(negedge clk);
    t0 = cyc;
    reseed = 1'b1; seed_in = 8'd0; req = 4'b0010;
    @(posedge clk); #1;
    check("reseed_idle_nostep", int'(busy), 0);
    @(negedge clk);
    reseed = 1'b0;
    wait_gnt(10, idx, val, at);
    check("reseed_idle_idx", idx, 1); check("reseed_idle_num", val, 197);
    check("reseed_idle_lat", at - t0, 3);

    // Reseed during STEP is deferred
    do_reset(4'b0001);
    @(negedge clk);
    check("step_busy", int'(busy), 1);
    reseed = 1'b1; seed_in = 8'd0;
    @(posedge clk); #1;
    check("defer_gnt", int'(gnt), 1); check("defer_num_old", int'(num), 56);
    prev = cyc;
    @(negedge clk);
    reseed = 1'b0;
    wait_gnt(10, idx, val, at);
    check("defer_num_new", val, 197); check("defer_gap", at - prev, 4);

    // Reset during STEP aborts the grant
    do_reset(4'b0110);
    @(negedge clk);
    check("abort_busy", int'(busy), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_gnt", int'(gnt), 0); check("abort_busy_rst", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    t0 = cyc;
    wait_gnt(10, idx, val, at);
    check("abort_idx", idx, 1); check("abort_num", val, 56); check("abort_lat", at - t0, 2);

`ifdef PRNG_ARB_STATS_EN
    do_reset(4'b0001);
    for (int g = 0; g < 5; g++) wait_gnt(10, idx, val, at);
    @(posedge clk); #1;
    check("stats_cnt5", int'(grant_cnt), 5);
    @(negedge clk);
    req = '0;
    repeat (3) @(negedge clk);
    reseed = 1'b1; seed_in = 8'd9;
    @(negedge clk);
    reseed = 1'b0;
    check("stats_cleared", int'(grant_cnt), 0);
    force dut.grant_cnt_q = 16'hFFFF;
    #1;
    release dut.grant_cnt_q;
    m_cnt = 65535;
    @(negedge clk);
    req = 4'b0001;
    wait_gnt(10, idx, val, at);
    @(posedge clk); #1;
    check("stats_saturate", int'(grant_cnt), 65535);
`endif

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog");
  end
endmodule
